// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: shared encodings for the multicycle RV32I control path and its alu.
package rv32i_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R, S_EXEC_I,
    S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
  } state_t;
  typedef logic [3:0] alu_ctrl_t;
  localparam alu_ctrl_t ALU_ADD    = 4'h0;
  localparam alu_ctrl_t ALU_SUB    = 4'h1;
  localparam alu_ctrl_t ALU_AND    = 4'h2;
  localparam alu_ctrl_t ALU_OR     = 4'h3;
  localparam alu_ctrl_t ALU_XOR    = 4'h4;
  localparam alu_ctrl_t ALU_SLL    = 4'h5;
  localparam alu_ctrl_t ALU_SRL    = 4'h6;
  localparam alu_ctrl_t ALU_SRA    = 4'h7;
  localparam alu_ctrl_t ALU_SLT    = 4'h8;
  localparam alu_ctrl_t ALU_SLTU   = 4'h9;
  localparam alu_ctrl_t ALU_PASS_B = 4'hA;
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_PASS_B} alu_op_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEM_ADR;
      OP_R:              return S_EXEC_R;
      OP_I:              return S_EXEC_I;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR;
      OP_LUI:            return S_LUI;
      OP_AUIPC:          return S_AUIPC;
      default:           return S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's coarse alu_op plus funct fields to a 4-bit alu_control.
module alu_decoder
  import rv32i_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output alu_ctrl_t  alu_control
);
  alu_ctrl_t funct_ctl;
  always_comb begin
    funct_ctl = ALU_ADD;
    case (funct3)
      3'b000: funct_ctl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: funct_ctl = ALU_SLL;
      3'b010: funct_ctl = ALU_SLT;
      3'b011: funct_ctl = ALU_SLTU;
      3'b100: funct_ctl = ALU_XOR;
      3'b101: funct_ctl = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: funct_ctl = ALU_OR;
      default: funct_ctl = ALU_AND;
    endcase
    alu_control = alu_op == AOP_SUB    ? ALU_SUB :
                  alu_op == AOP_PASS_B ? ALU_PASS_B :
                  alu_op == AOP_FUNCT  ? funct_ctl : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM driving the shared alu, muxes, PC, IR, regfile and memory port.
module multicycle_controller
  import rv32i_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       equal,
  input  logic       less_than,
  input  logic       less_than_unsigned,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);
  state_t    state_q, state_d;
  alu_op_t   alu_op;
  alu_ctrl_t alu_ctl;
  logic      br_cond, br_bad;
  // funct3[2:1] picks the compared flag, funct3[0] inverts it
  assign br_cond = (funct3[2] ? (funct3[1] ? less_than_unsigned : less_than) : equal) ^ funct3[0];
  assign br_bad  = funct3[2:1] == 2'b01;
  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .is_rtype   (state_q == S_EXEC_R),
    .alu_control(alu_ctl)
  );
  assign alu_control = alu_ctl;
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALU_OUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    alu_op     = AOP_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
        imm_src   = op == OP_JAL ? IMM_J : IMM_B;
        state_d   = decode_next(op);
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = op == OP_STORE ? IMM_S : IMM_I;
        state_d   = op == OP_STORE ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = AOP_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = AOP_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = AOP_SUB;
        pc_write  = br_cond && !br_bad;
        state_d   = br_bad ? S_TRAP : S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        alu_op    = AOP_PASS_B;
        state_d   = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALU_WB;
      end
      default: illegal = 1'b1;
    endcase
    // reset masks strobes in the same cycle so an aborted instruction never commits
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;
endmodule
